// File: rtl/exe_slice_seq_pkg.sv
// Shared types for the bit-serial execute/writeback sequencer and its decode stage.
package exe_slice_seq_pkg;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_EQ,
      ALU_LT,
      ALU_LTU
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_SEL_ALU = 2'd0,
      WB_SEL_LSU = 2'd1,
      WB_SEL_WB  = 2'd2
   } wb_sel_e;

   // Compare ops produce a flag only and never write the register file.
   function automatic logic is_cmp(alu_op_e op);
      return op inside {ALU_EQ, ALU_LT, ALU_LTU};
   endfunction

   // Ops that compute a - b (inverted b, carry-in 1 on the first slice).
   function automatic logic uses_sub(alu_op_e op);
      return op inside {ALU_SUB, ALU_EQ, ALU_LT, ALU_LTU};
   endfunction

endpackage

// File: rtl/exe_slice_seq_alu_slice.sv
// One SLICE_W-wide slice of the serial ALU; carry is chained by the caller.
module exe_slice_seq_alu_slice
   import exe_slice_seq_pkg::*;
#(
   parameter int unsigned SLICE_W = 16
) (
   input  alu_op_e              op,
   input  logic [SLICE_W-1:0]   a,
   input  logic [SLICE_W-1:0]   b,
   input  logic                 cin,
   output logic [SLICE_W-1:0]   result,
   output logic                 cout,
   output logic                 ovf,
   output logic                 eq
);

   logic [SLICE_W-1:0] b_eff;
   logic [SLICE_W:0]   sum;

   // Adder/subtractor plus logic ops; overflow is only meaningful on the top slice.
   always_comb begin
      b_eff  = uses_sub(op) ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
      ovf    = (a[SLICE_W-1] == b_eff[SLICE_W-1]) && (sum[SLICE_W-1] != a[SLICE_W-1]);
      eq     = (a == b);
      cout   = 1'b0;
      result = sum[SLICE_W-1:0];
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         default: begin
            result = sum[SLICE_W-1:0];
            cout   = sum[SLICE_W];
         end
      endcase
   end

endmodule

// File: rtl/exe_slice_seq.sv
// Bit-serial execute/writeback sequencer: one instruction as NSLICE slices, LSB first.
module exe_slice_seq
   import exe_slice_seq_pkg::*;
#(
   parameter int unsigned DAT_W = 32,
   parameter int unsigned SLICE_W = 16,
   localparam int unsigned NSLICE = DAT_W / SLICE_W,
   localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   output logic               ready_o,
   input  alu_op_e            op_i,
   input  logic               cmp_flip_i,
   input  wb_sel_e            wb_sel_i,
   input  logic               rf_write_i,
   input  logic [DAT_W-1:0]   wb_data_i,
   input  logic [SLICE_W-1:0] a_slice_i,
   input  logic [SLICE_W-1:0] b_slice_i,
   output logic [IDX_W-1:0]   slice_idx_o,
   output logic               lsu_req_o,
   input  logic               lsu_valid_i,
   input  logic               lsu_err_i,
   input  logic [DAT_W-1:0]   lsu_data_i,
   output logic               rf_we_o,
   output logic [SLICE_W-1:0] rf_wdata_o,
   output logic               cmp_result_o,
   output logic               cmp_valid_o,
   output logic               done_o,
   output logic               err_o
);

   if ((DAT_W % SLICE_W) != 0) begin : g_bad_slice_w
      $error("SLICE_W must divide DAT_W");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {StIdle, StLsuWait, StRun} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q, eq_q;
   alu_op_e            op_q;
   logic               flip_q, rf_write_q;
   wb_sel_e            wb_sel_q;
   logic [DAT_W-1:0]   wb_data_q, ld_data_q;
   logic               cmp_result_q, cmp_valid_q, done_q, err_q;

   logic [SLICE_W-1:0] alu_res;
   logic               alu_cout, alu_ovf, alu_eq;
   logic               last_slice, cmp_raw;
   logic [SLICE_W-1:0] wb_slice;

   exe_slice_seq_alu_slice #(
      .SLICE_W (SLICE_W)
   ) u_alu_slice (
      .op     (op_q),
      .a      (a_slice_i),
      .b      (b_slice_i),
      .cin    (carry_q),
      .result (alu_res),
      .cout   (alu_cout),
      .ovf    (alu_ovf),
      .eq     (alu_eq)
   );

   assign last_slice = (idx_q == LAST_IDX);

   // Next-state decode and the compare flag as seen on the final slice.
   always_comb begin
      state_d = state_q;
      cmp_raw = 1'b0;
      case (state_q)
         StIdle:    if (valid_i) state_d = (wb_sel_i == WB_SEL_LSU) ? StLsuWait : StRun;
         StLsuWait: if (lsu_valid_i) state_d = lsu_err_i ? StIdle : StRun;
         StRun:     if (last_slice) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      case (op_q)
         ALU_EQ:  cmp_raw = eq_q & alu_eq;
         ALU_LT:  cmp_raw = alu_res[SLICE_W-1] ^ alu_ovf;
         ALU_LTU: cmp_raw = ~alu_cout;
         default: cmp_raw = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Operand latching, slice counter, carry/eq chaining and the registered pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q        <= '0;
         carry_q      <= 1'b0;
         eq_q         <= 1'b1;
         op_q         <= ALU_ADD;
         flip_q       <= 1'b0;
         wb_sel_q     <= WB_SEL_ALU;
         rf_write_q   <= 1'b0;
         wb_data_q    <= '0;
         ld_data_q    <= '0;
         cmp_result_q <= 1'b0;
         cmp_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         cmp_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            StIdle: begin
               if (valid_i) begin
                  op_q       <= op_i;
                  flip_q     <= cmp_flip_i;
                  wb_sel_q   <= wb_sel_i;
                  rf_write_q <= rf_write_i;
                  wb_data_q  <= wb_data_i;
                  idx_q      <= '0;
                  // Carry-in of slice 0 is preloaded here so the ALU always reads carry_q.
                  carry_q    <= uses_sub(op_i);
                  eq_q       <= 1'b1;
               end
            end
            StLsuWait: begin
               if (lsu_valid_i) begin
                  if (lsu_err_i) err_q     <= 1'b1;
                  else           ld_data_q <= lsu_data_i;
               end
            end
            StRun: begin
               carry_q <= alu_cout;
               eq_q    <= eq_q & alu_eq;
               if (last_slice) begin
                  idx_q  <= '0;
                  done_q <= 1'b1;
                  if (is_cmp(op_q)) begin
                     cmp_valid_q  <= 1'b1;
                     cmp_result_q <= cmp_raw ^ flip_q;
                  end
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Writeback source select; write data is forced to zero when no write is issued.
   always_comb begin
      wb_slice = alu_res;
      unique case (wb_sel_q)
         WB_SEL_ALU: wb_slice = alu_res;
         WB_SEL_LSU: wb_slice = ld_data_q[idx_q*SLICE_W +: SLICE_W];
         WB_SEL_WB:  wb_slice = wb_data_q[idx_q*SLICE_W +: SLICE_W];
         default:    wb_slice = alu_res;
      endcase
      // rst gates the write in the reset cycle itself, before the state has cleared.
      rf_we_o    = (state_q == StRun) && rf_write_q && !is_cmp(op_q) && !rst;
      rf_wdata_o = rf_we_o ? wb_slice : '0;
   end

   assign ready_o      = (state_q == StIdle);
   assign lsu_req_o    = (state_q == StLsuWait);
   assign slice_idx_o  = idx_q;
   assign cmp_result_o = cmp_result_q;
   assign cmp_valid_o  = cmp_valid_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_exe_slice_seq.sv
// Bench for exe_slice_seq: a 2-slice (16b) and a 4-slice (8b) instance share all stimulus.
module tb_exe_slice_seq;
   import exe_slice_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        valid = 1'b0, flip = 1'b0, rf_write = 1'b0;
   alu_op_e     op = ALU_ADD;
   wb_sel_e     wb_sel = WB_SEL_ALU;
   logic [31:0] wb_data = '0, a_full = '0, b_full = '0, lsu_data = '0;
   logic        lsu_valid = 1'b0, lsu_err = 1'b0;

   logic        ready16, req16, we16, cmpr16, cmpv16, done16, err16;
   logic [0:0]  idx16;
   logic [15:0] w16, a16, b16;
   logic        ready8, req8, we8, cmpr8, cmpv8, done8, err8;
   logic [1:0]  idx8;
   logic [7:0]  w8, a8, b8;

   // Regfile model: return the slice addressed by each DUT.
   assign a16 = 16'(a_full >> (32'(idx16) * 16));
   assign b16 = 16'(b_full >> (32'(idx16) * 16));
   assign a8  = 8'(a_full >> (32'(idx8) * 8));
   assign b8  = 8'(b_full >> (32'(idx8) * 8));

   exe_slice_seq #(.DAT_W(32), .SLICE_W(16)) dut16 (
      .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready16), .op_i(op),
      .cmp_flip_i(flip), .wb_sel_i(wb_sel), .rf_write_i(rf_write), .wb_data_i(wb_data),
      .a_slice_i(a16), .b_slice_i(b16), .slice_idx_o(idx16), .lsu_req_o(req16),
      .lsu_valid_i(lsu_valid), .lsu_err_i(lsu_err), .lsu_data_i(lsu_data),
      .rf_we_o(we16), .rf_wdata_o(w16), .cmp_result_o(cmpr16), .cmp_valid_o(cmpv16),
      .done_o(done16), .err_o(err16)
   );

   exe_slice_seq #(.DAT_W(32), .SLICE_W(8)) dut8 (
      .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready8), .op_i(op),
      .cmp_flip_i(flip), .wb_sel_i(wb_sel), .rf_write_i(rf_write), .wb_data_i(wb_data),
      .a_slice_i(a8), .b_slice_i(b8), .slice_idx_o(idx8), .lsu_req_o(req8),
      .lsu_valid_i(lsu_valid), .lsu_err_i(lsu_err), .lsu_data_i(lsu_data),
      .rf_we_o(we8), .rf_wdata_o(w8), .cmp_result_o(cmpr8), .cmp_valid_o(cmpv8),
      .done_o(done8), .err_o(err8)
   );

   typedef struct {
      bit          ready, req, we, run, done, cmpv, cmp_set, cmp_val, err;
      int          idx;
      logic [15:0] wdata;
   } exp_t;

   localparam int NCYC = 2048;
   exp_t ex [2][NCYC];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   bit   held [2] = '{1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, d, cyc, act, exp);
      end
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e.ready = 1'b1; e.req = 1'b0; e.we = 1'b0; e.run = 1'b0; e.done = 1'b0;
      e.cmpv = 1'b0; e.cmp_set = 1'b0; e.cmp_val = 1'b0; e.err = 1'b0;
      e.idx = 0; e.wdata = '0;
      return e;
   endfunction

   // Whole-word reference result of each operation.
   function automatic logic [31:0] alu_model(alu_op_e o, logic [31:0] a, logic [31:0] b);
      case (o)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_EQ:  return {31'b0, a == b};
         ALU_LT:  return {31'b0, $signed(a) < $signed(b)};
         default: return {31'b0, a < b};
      endcase
   endfunction

   // Fill the expected per-cycle outputs of both instances for one instruction.
   task automatic sched(input int t, input alu_op_e o, input bit f, input wb_sel_e s,
                        input bit rfw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] wbd, input int l, input bit lerr,
                        input logic [31:0] ld);
      for (int d = 0; d < 2; d++) begin
         int          w, n, st;
         logic [31:0] res, val, mask;
         bit          cmp;
         w    = (d == 0) ? 16 : 8;
         n    = 32 / w;
         mask = (d == 0) ? 32'hFFFF : 32'hFF;
         st   = t;
         if (s == WB_SEL_LSU) begin
            for (int c = t + 1; c <= l; c++) begin
               ex[d][c].ready = 1'b0;
               ex[d][c].req   = 1'b1;
            end
            st = l;
         end
         if (s == WB_SEL_LSU && lerr) begin
            ex[d][l + 1].err = 1'b1;
         end else begin
            res = alu_model(o, a, b);
            val = (s == WB_SEL_ALU) ? res : (s == WB_SEL_LSU) ? ld : wbd;
            cmp = (o == ALU_EQ) || (o == ALU_LT) || (o == ALU_LTU);
            for (int k = 0; k < n; k++) begin
               ex[d][st + 1 + k].ready = 1'b0;
               ex[d][st + 1 + k].run   = 1'b1;
               ex[d][st + 1 + k].idx   = k;
               ex[d][st + 1 + k].we    = rfw && !cmp;
               ex[d][st + 1 + k].wdata = 16'((val >> (k * w)) & mask);
            end
            ex[d][st + n + 1].done = 1'b1;
            if (cmp) begin
               ex[d][st + n + 1].cmpv    = 1'b1;
               ex[d][st + n + 1].cmp_set = 1'b1;
               ex[d][st + n + 1].cmp_val = res[0] ^ f;
            end
         end
      end
   endtask

   // Reset asserted during cycle c: nothing written in c, everything idle from c+1.
   task automatic model_reset(input int c);
      for (int d = 0; d < 2; d++) begin
         ex[d][c].we = 1'b0;
         for (int cc = c + 1; cc < c + 24; cc++) ex[d][cc] = idle_exp();
         ex[d][c + 1].cmp_set = 1'b1;
         ex[d][c + 1].cmp_val = 1'b0;
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            exp_t e;
            e = ex[d][cyc];
            if (e.cmp_set) held[d] = e.cmp_val;
            chk("ready", d, (d == 0) ? ready16 : ready8, e.ready);
            chk("lsu_req", d, (d == 0) ? req16 : req8, e.req);
            chk("rf_we", d, (d == 0) ? we16 : we8, e.we);
            chk("done", d, (d == 0) ? done16 : done8, e.done);
            chk("cmp_valid", d, (d == 0) ? cmpv16 : cmpv8, e.cmpv);
            chk("cmp_result", d, (d == 0) ? cmpr16 : cmpr8, held[d]);
            chk("err", d, (d == 0) ? err16 : err8, e.err);
            if (e.run) chk("slice_idx", d, (d == 0) ? 32'(idx16) : 32'(idx8), e.idx);
            if (e.we) chk("rf_wdata", d, (d == 0) ? 32'(w16) : 32'(w8), 32'(e.wdata));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Offer one instruction; for loads also deliver the LSU response at accept+lat.
   task automatic start_op(input alu_op_e o, input bit f, input wb_sel_e s, input bit rfw,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] wbd,
                           input int lat, input bit lerr, input logic [31:0] ld,
                           input bit early, output int t);
      t = cyc;
      op = o; flip = f; wb_sel = s; rf_write = rfw; wb_data = wbd;
      a_full = a; b_full = b;
      valid = 1'b1; lsu_valid = early; lsu_err = early; lsu_data = 32'h0BAD0BAD;
      sched(t, o, f, s, rfw, a, b, wbd, t + lat, lerr, ld);
      tick();
      // Scramble the offered fields so an unlatched field shows up as a wrong result.
      valid = 1'b0; lsu_valid = 1'b0; lsu_err = 1'b0;
      op = ALU_XOR; flip = ~f; wb_sel = WB_SEL_WB; rf_write = ~rfw; wb_data = 32'hA5A5A5A5;
      if (s == WB_SEL_LSU) begin
         while (cyc < t + lat) tick();
         lsu_valid = 1'b1; lsu_err = lerr; lsu_data = ld;
         tick();
         lsu_valid = 1'b0; lsu_err = 1'b0; lsu_data = 32'h0BAD0BAD;
      end
   endtask

   task automatic settle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int t;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCYC; c++) ex[d][c] = idle_exp();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      settle(2);

      // ADD carry ripples from slice 0 into slice 1.
      start_op(ALU_ADD, 1'b0, WB_SEL_ALU, 1'b1, 32'h0000FFFF, 32'h1, '0, 0, 1'b0, '0, 1'b0, t);
      chk("lit_add_s0", 0, {we16, w16}, {1'b1, 16'h0000});
      tick();
      chk("lit_add_s1", 0, {we16, w16}, {1'b1, 16'h0001});
      tick();
      chk("lit_add_done", 0, {done16, ready16}, 2'b11);
      settle(3);

      // SUB borrow through every byte slice.
      start_op(ALU_SUB, 1'b0, WB_SEL_ALU, 1'b1, 32'h0, 32'h1, '0, 0, 1'b0, '0, 1'b0, t);
      for (int k = 0; k < 4; k++) begin
         chk("lit_sub_slice", 1, {we8, w8}, {1'b1, 8'hFF});
         tick();
      end
      chk("lit_sub_done", 1, done8, 1'b1);
      settle(1);

      start_op(ALU_LT, 1'b0, WB_SEL_ALU, 1'b1, 32'h80000000, 32'h1, '0, 0, 1'b0, '0, 1'b0, t);
      settle(2);
      chk("lit_lt", 0, {cmpv16, cmpr16}, 2'b11);
      settle(3);
      start_op(ALU_LTU, 1'b0, WB_SEL_ALU, 1'b1, 32'h80000000, 32'h1, '0, 0, 1'b0, '0, 1'b0, t);
      settle(2);
      chk("lit_ltu", 0, {cmpv16, cmpr16}, 2'b10);
      settle(3);
      start_op(ALU_EQ, 1'b1, WB_SEL_ALU, 1'b1, 32'h12345678, 32'h12345678, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(4);
      chk("lit_eq_flip", 1, {cmpv8, cmpr8}, 2'b10);
      settle(1);

      // More compare corners: eq across slices, signed overflow, unsigned wrap.
      start_op(ALU_EQ, 1'b0, WB_SEL_ALU, 1'b0, 32'h12345678, 32'h12345678, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_EQ, 1'b0, WB_SEL_ALU, 1'b0, 32'h12345678, 32'h12355678, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_LT, 1'b0, WB_SEL_ALU, 1'b1, 32'h00000005, 32'h80000000, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_LT, 1'b1, WB_SEL_ALU, 1'b1, 32'hFFFFFFFF, 32'h0, '0, 0, 1'b0, '0, 1'b0, t);
      settle(5);
      start_op(ALU_LTU, 1'b0, WB_SEL_ALU, 1'b0, 32'h1, 32'hFFFFFFFF, '0, 0, 1'b0, '0, 1'b0, t);
      settle(5);

      // Logic ops, immediate writeback, and a non-writing ADD.
      start_op(ALU_AND, 1'b0, WB_SEL_ALU, 1'b1, 32'hF0F0FF00, 32'h3C3C0FF0, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_OR, 1'b0, WB_SEL_ALU, 1'b1, 32'hF0F0FF00, 32'h3C3C0FF0, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_XOR, 1'b0, WB_SEL_ALU, 1'b1, 32'hF0F0FF00, 32'h3C3C0FF0, '0, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_ADD, 1'b0, WB_SEL_WB, 1'b1, 32'h11111111, 32'h1, 32'hCAFEF00D, 0, 1'b0, '0,
               1'b0, t);
      settle(5);
      start_op(ALU_ADD, 1'b0, WB_SEL_ALU, 1'b0, 32'h7, 32'h9, '0, 0, 1'b0, '0, 1'b0, t);
      settle(5);

      // Back-to-back: second accept in the cycle the 4-slice instance reports done.
      start_op(ALU_ADD, 1'b0, WB_SEL_ALU, 1'b1, 32'h00FF00FF, 32'h00010001, '0, 0, 1'b0, '0,
               1'b0, t);
      while (cyc < t + 5) tick();
      start_op(ALU_SUB, 1'b0, WB_SEL_ALU, 1'b1, 32'h10000000, 32'h1, '0, 0, 1'b0, '0, 1'b0, t);
      settle(5);

      // Load: response 3 cycles after the request starts; stray valid in accept cycle.
      start_op(ALU_ADD, 1'b0, WB_SEL_LSU, 1'b1, '0, '0, '0, 4, 1'b0, 32'hDEADBEEF, 1'b1, t);
      chk("lit_ld_s0", 0, {we16, w16}, {1'b1, 16'hBEEF});
      tick();
      chk("lit_ld_s1", 0, {we16, w16}, {1'b1, 16'hDEAD});
      settle(4);

      // Faulting load.
      start_op(ALU_ADD, 1'b0, WB_SEL_LSU, 1'b1, '0, '0, '0, 2, 1'b1, 32'h12345678, 1'b0, t);
      chk("lit_ld_err", 0, {err16, ready16, we16}, 3'b110);
      settle(3);

      // Reset during slice 0 of a 4-slice ADD, then a clean ADD.
      start_op(ALU_ADD, 1'b0, WB_SEL_ALU, 1'b1, 32'h12345678, 32'h11111111, '0, 0, 1'b0, '0,
               1'b0, t);
      rst = 1'b1;
      model_reset(cyc);
      #1;
      chk("lit_rst_we", 1, we8, 1'b0);
      tick();
      rst = 1'b0;
      chk("lit_rst_idle", 1, {ready8, we8}, 2'b10);
      settle(2);
      start_op(ALU_ADD, 1'b0, WB_SEL_ALU, 1'b1, 32'h1, 32'h1, '0, 0, 1'b0, '0, 1'b0, t);
      chk("lit_post_rst_s0", 1, {we8, w8}, {1'b1, 8'h02});
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("lit_post_rst_sk", 1, {we8, w8}, {1'b1, 8'h00});
      end
      settle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
